lc3b_mem_ctrl: RTL and testbench
================================

# lc3b_mem_ctrl

Memory access sequencer for the LC-3b datapath. It accepts one load/store request at a time from the control FSM, drives the memory port through a ready handshake, and applies byte-lane selection and store replication. For byte loads (LDB) it steers the addressed byte to bits [7:0] and extends it to 16 bits before handing the result back to the MDR. It also flags misaligned word accesses and memory timeouts.

## Interface
- WAIT_LIMIT, 15, maximum cycles spent waiting on `mem_r` before aborting with error (1..255)
- clk_50  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  start request, sampled only in IDLE
- we  input  1  1 = store, 0 = load (captured with req)
- byte  input  1  1 = byte access, 0 = word access (captured with req)
- addr  input  16  byte address (captured with req)
- wdata  input  16  store data (captured with req)
- busy  output  1  high from the cycle after an accepted req until done/err pulses
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done
- rdata  output  16  load result, valid with done, held until next completion
- mem_addr  output  16  word address to memory, {addr[15:1],1'b0}
- mem_wdata  output  16  store data to memory
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_be  output  2  byte enables, [1]=high byte, [0]=low byte
- mem_rdata  input  16  memory read data, valid when mem_r high
- mem_r  input  1  memory ready

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE: on req=1 capture we/byte/addr/wdata. If byte=0 and addr[0]=1 -> ERR; else -> ACCESS. req=0 stays IDLE.
- ACCESS: mem_en=1, mem_we=captured we, mem_addr/mem_wdata/mem_be stable for whole state. On mem_r=1 -> DONE (load data captured same edge). Wait counter increments each ACCESS cycle with mem_r=0; reaching WAIT_LIMIT -> ERR.
- DONE: done=1 one cycle, -> IDLE.
- ERR: done=1, err=1 one cycle, rdata unchanged, -> IDLE. No memory strobe issued for misaligned requests.
- req in any state other than IDLE is ignored (not queued).
- Word store: mem_wdata=wdata, mem_be=2'b11. Byte store: mem_wdata={wdata[7:0],wdata[7:0]}, mem_be=addr[0]?2'b10:2'b01.
- Word load: rdata=mem_rdata. Byte load: b=addr[0]?mem_rdata[15:8]:mem_rdata[7:0]; rdata={8'h00,b} (see Configuration).
- Stores leave rdata unchanged.

## Timing
- Reset: state IDLE, busy=0, done=0, err=0, rdata=16'h0000, mem_en=0, mem_we=0, mem_be=2'b00, mem_addr=0, mem_wdata=0, wait counter 0.
- Outside ACCESS: mem_en=0, mem_we=0, mem_be=2'b00.
- Latency: req at edge N -> mem_en high from cycle N+1; mem_r sampled high at edge K -> done high in cycle K+1. Zero-wait memory: req to done = 2 cycles.
- Misaligned: req at N -> done+err in cycle N+1.
- Timeout: mem_r low for WAIT_LIMIT consecutive ACCESS cycles -> err pulse next cycle; a mem_r arriving in the same cycle the limit is reached wins (normal completion).
- Reset asserted mid-ACCESS: next cycle all outputs at reset values, no done pulse, pending access abandoned.
- New req accepted in the cycle after done (back-to-back throughput: one access per 2+wait cycles).

## Configuration
- LDB_SEXT_EN defined: byte loads sign-extend, rdata={{8{b[7]}},b} (ISA-compliant LDB).
- LDB_SEXT_EN undefined: byte loads zero-extend, rdata={8'h00,b}. Word accesses unaffected either way.

## Test plan
- Word load 0x3000, mem_r high 1st ACCESS cycle, mem_rdata=16'hBEEF -> mem_addr=16'h3000, mem_be=2'b11, done 2 cycles after req, rdata=16'hBEEF, err=0.
- Byte load addr=16'h3001, mem_rdata=16'h80FF -> mem_be=2'b10, rdata=16'h0080 (macro off) / 16'hFF80 (LDB_SEXT_EN).
- Byte store addr=16'h4000, wdata=16'h12AB, 3 wait cycles -> mem_wdata=16'hABAB, mem_be=2'b01, mem_we=1 held 4 cycles, done 1 cycle after mem_r, rdata unchanged.
- Word load addr=16'h3003 -> no mem_en, done=1 and err=1 in cycle after req, busy low after.
- mem_r held low, WAIT_LIMIT=15 -> mem_en high 15 cycles, then done+err; second req during busy ignored.
- reset pulsed during ACCESS -> all outputs at reset values next cycle, no done; subsequent req completes normally.

Source files
------------

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl: load/store sequencer between the LC-3b control FSM and memory.
// Accepts one request at a time, runs the mem_en/mem_r handshake, and handles
// byte-lane enables, byte-store replication, LDB byte steering, misaligned
// word detection and memory timeouts.
// Optional build macro: LDB_SEXT_EN (byte loads sign-extend instead of zero-extend).
`timescale 1ns/1ps

module lc3b_mem_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_acc,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        cap_we;
    logic        cap_byte;
    logic        cap_lane;
    logic [7:0]  wait_cnt;
    logic        misaligned;
    logic        timeout;
    logic [7:0]  sel_byte;
    logic [15:0] load_value;

    assign misaligned = !byte_acc && addr[0];
    assign timeout    = (wait_cnt == 8'(WAIT_LIMIT - 1));

    // State register
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/strobe decoding
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 2'b00;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = misaligned ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                mem_we = cap_we;
                mem_be = cap_byte ? (cap_lane ? 2'b10 : 2'b01) : 2'b11;
                if (mem_r) begin
                    next_state = DONE;
                end else if (timeout) begin
                    next_state = ERR;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                busy       = 1'b1;
                done       = 1'b1;
                err        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request; address and store data stay frozen for the whole access
    always_ff @(posedge clk_50) begin
        if (reset) begin
            cap_we    <= 1'b0;
            cap_byte  <= 1'b0;
            cap_lane  <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
        end else if (state == IDLE && req) begin
            cap_we    <= we;
            cap_byte  <= byte_acc;
            cap_lane  <= addr[0];
            mem_addr  <= {addr[15:1], 1'b0};
            mem_wdata <= byte_acc ? {wdata[7:0], wdata[7:0]} : wdata;
        end
    end

    // Count ACCESS cycles spent without mem_r; cleared whenever not in ACCESS
    always_ff @(posedge clk_50) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (state == ACCESS && !mem_r) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Steer the addressed byte to the low lane and extend it for LDB
    always_comb begin
        sel_byte = cap_lane ? mem_rdata[15:8] : mem_rdata[7:0];
`ifdef LDB_SEXT_EN
        load_value = cap_byte ? {{8{sel_byte[7]}}, sel_byte} : mem_rdata;
`else
        load_value = cap_byte ? {8'h00, sel_byte} : mem_rdata;
`endif
    end

    // Load result register, updated only when a load completes normally
    always_ff @(posedge clk_50) begin
        if (reset) begin
            rdata <= 16'h0000;
        end else if (state == ACCESS && mem_r && !cap_we) begin
            rdata <= load_value;
        end
    end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb_lc3b_mem_ctrl: directed self-checking bench for lc3b_mem_ctrl.
`timescale 1ns/1ps

module tb_lc3b_mem_ctrl;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic        byte_acc;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;
    logic        mem_r;

    int check_count = 0;
    int error_count = 0;

    lc3b_mem_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .byte_acc  (byte_acc),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_r     (mem_r)
    );

    always #5 clk_50 = ~clk_50;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 16'h%04h, expected 16'h%04h", tag, actual, expected);
        end
    endtask

    // Present a one-cycle request, leaving the DUT in the cycle after acceptance
    task automatic applyStimulus(input logic st, input logic bt, input logic [15:0] a, input logic [15:0] d);
        req      = 1'b1;
        we       = st;
        byte_acc = bt;
        addr     = a;
        wdata    = d;
        tick();
        req      = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},   16'(busy),      16'h0);
        checkOutput({tag, "_done"},   16'(done),      16'h0);
        checkOutput({tag, "_err"},    16'(err),       16'h0);
        checkOutput({tag, "_rdata"},  rdata,          16'h0000);
        checkOutput({tag, "_en"},     16'(mem_en),    16'h0);
        checkOutput({tag, "_we"},     16'(mem_we),    16'h0);
        checkOutput({tag, "_be"},     16'(mem_be),    16'h0);
        checkOutput({tag, "_maddr"},  mem_addr,       16'h0000);
        checkOutput({tag, "_mwdata"}, mem_wdata,      16'h0000);
    endtask

    logic [15:0] ldb_expected;

    initial begin
`ifdef LDB_SEXT_EN
        ldb_expected = 16'hFF80;
`else
        ldb_expected = 16'h0080;
`endif
        reset = 1'b1; req = 1'b0; we = 1'b0; byte_acc = 1'b0;
        addr = 16'h0; wdata = 16'h0; mem_rdata = 16'h0; mem_r = 1'b0;
        tick();
        tick();
        checkResetValues("rst");
        reset = 1'b0;
        tick();

        // Word load, zero-wait memory
        mem_r = 1'b1; mem_rdata = 16'hBEEF;
        applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000);
        checkOutput("wl_busy",  16'(busy),   16'h1);
        checkOutput("wl_en",    16'(mem_en), 16'h1);
        checkOutput("wl_we",    16'(mem_we), 16'h0);
        checkOutput("wl_addr",  mem_addr,    16'h3000);
        checkOutput("wl_be",    16'(mem_be), 16'h3);
        checkOutput("wl_done0", 16'(done),   16'h0);
        tick();
        checkOutput("wl_done",  16'(done),   16'h1);
        checkOutput("wl_err",   16'(err),    16'h0);
        checkOutput("wl_rdata", rdata,       16'hBEEF);
        checkOutput("wl_en_off",16'(mem_en), 16'h0);
        tick();
        checkOutput("wl_idle_done", 16'(done), 16'h0);
        checkOutput("wl_idle_busy", 16'(busy), 16'h0);

        // Byte load from the odd (high) lane
        mem_rdata = 16'h80FF;
        applyStimulus(1'b0, 1'b1, 16'h3001, 16'h0000);
        checkOutput("bl_be",    16'(mem_be), 16'h2);
        checkOutput("bl_addr",  mem_addr,    16'h3000);
        tick();
        checkOutput("bl_done",  16'(done),   16'h1);
        checkOutput("bl_rdata", rdata,       ldb_expected);
        tick();

        // Byte store to the even lane with three wait cycles
        mem_r = 1'b0; mem_rdata = 16'h5555;
        applyStimulus(1'b1, 1'b1, 16'h4000, 16'h12AB);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_r = 1'b1;
            checkOutput($sformatf("bs_we%0d", i),    16'(mem_we), 16'h1);
            checkOutput($sformatf("bs_done%0d", i),  16'(done),   16'h0);
            if (i < 3) tick();
        end
        checkOutput("bs_wdata", mem_wdata,   16'hABAB);
        checkOutput("bs_be",    16'(mem_be), 16'h1);
        checkOutput("bs_addr",  mem_addr,    16'h4000);
        tick();
        checkOutput("bs_done",  16'(done),   16'h1);
        checkOutput("bs_err",   16'(err),    16'h0);
        checkOutput("bs_rdata", rdata,       ldb_expected);
        tick();
        mem_r = 1'b0;

        // Misaligned word load
        applyStimulus(1'b0, 1'b0, 16'h3003, 16'h0000);
        checkOutput("mis_en",    16'(mem_en), 16'h0);
        checkOutput("mis_done",  16'(done),   16'h1);
        checkOutput("mis_err",   16'(err),    16'h1);
        checkOutput("mis_rdata", rdata,       ldb_expected);
        tick();
        checkOutput("mis_busy",  16'(busy),   16'h0);
        checkOutput("mis_done1", 16'(done),   16'h0);

        // Timeout with a second request presented while busy
        applyStimulus(1'b0, 1'b0, 16'h5000, 16'h0000);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("to_en%0d", i),   16'(mem_en), 16'h1);
            checkOutput($sformatf("to_done%0d", i), 16'(done),   16'h0);
            req = (i == 3);
            we = 1'b0; byte_acc = 1'b0; addr = 16'h7000;
            tick();
        end
        req = 1'b0;
        checkOutput("to_done", 16'(done),   16'h1);
        checkOutput("to_err",  16'(err),    16'h1);
        checkOutput("to_en_off", 16'(mem_en), 16'h0);
        checkOutput("to_rdata", rdata,      ldb_expected);
        tick();
        checkOutput("to_busy_after", 16'(busy), 16'h0);
        checkOutput("to_no_requeue", 16'(done), 16'h0);

        // mem_r arrives in the cycle the limit is reached: normal completion
        mem_rdata = 16'h2468;
        applyStimulus(1'b0, 1'b0, 16'h5002, 16'h0000);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("lim_en", 16'(mem_en), 16'h1);
        mem_r = 1'b1;
        tick();
        mem_r = 1'b0;
        checkOutput("lim_done",  16'(done), 16'h1);
        checkOutput("lim_err",   16'(err),  16'h0);
        checkOutput("lim_rdata", rdata,     16'h2468);
        tick();

        // Reset during ACCESS abandons the access
        applyStimulus(1'b1, 1'b0, 16'h6000, 16'hCAFE);
        checkOutput("ra_en", 16'(mem_en), 16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetValues("ra");
        tick();
        checkOutput("ra_no_done", 16'(done), 16'h0);

        // Subsequent request completes normally
        mem_r = 1'b1; mem_rdata = 16'h1234;
        applyStimulus(1'b0, 1'b0, 16'h6002, 16'h0000);
        checkOutput("post_addr", mem_addr, 16'h6002);
        tick();
        checkOutput("post_done",  16'(done), 16'h1);
        checkOutput("post_rdata", rdata,     16'h1234);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
